video_timing_gen: RTL

Generates the raster timing (sync, data-enable, pixel coordinates, frame and line strobes) for the output video path. It is clocked from the 25.2 MHz pixel clock produced by the system PLL and consumes that PLL's `locked` flag. Timing starts only after a debounced lock and stops cleanly on loss of lock. Default parameters give 640x480 at 60 Hz (800x525 total).

---
 rtl/video_pkg.sv | 47 ++++
 rtl/sync_2ff.sv | 21 ++
 rtl/video_timing_gen.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared raster timing types, default 640x480@60 constants and total helpers
package video_pkg;

    localparam int unsigned DEF_H_ACTIVE      = 640;
    localparam int unsigned DEF_H_FP          = 16;
    localparam int unsigned DEF_H_SYNC        = 96;
    localparam int unsigned DEF_H_BP          = 48;
    localparam int unsigned DEF_V_ACTIVE      = 480;
    localparam int unsigned DEF_V_FP          = 10;
    localparam int unsigned DEF_V_SYNC        = 2;
    localparam int unsigned DEF_V_BP          = 33;
    localparam int unsigned DEF_SETTLE_CYCLES = 16;

    localparam int unsigned H_TOTAL_MAX = 2048;
    localparam int unsigned V_TOTAL_MAX = 1024;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } video_mode_t;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } vtg_state_t;

    function automatic int unsigned axis_total(axis_timing_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

    function automatic int unsigned h_total(video_mode_t m);
        return axis_total(m.h);
    endfunction

    function automatic int unsigned v_total(video_mode_t m);
        return axis_total(m.v);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer, asynchronous active-low reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator gated by a debounced PLL lock
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = DEF_H_ACTIVE,
    parameter int unsigned H_FP          = DEF_H_FP,
    parameter int unsigned H_SYNC        = DEF_H_SYNC,
    parameter int unsigned H_BP          = DEF_H_BP,
    parameter int unsigned V_ACTIVE      = DEF_V_ACTIVE,
    parameter int unsigned V_FP          = DEF_V_FP,
    parameter int unsigned V_SYNC        = DEF_V_SYNC,
    parameter int unsigned V_BP          = DEF_V_BP,
    parameter bit          HS_POL        = 1'b0,
    parameter bit          VS_POL        = 1'b0,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_locked,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic        running
);

    localparam video_mode_t MODE = '{
        h: '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP},
        v: '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP}
    };
    localparam int unsigned H_TOTAL = h_total(MODE);
    localparam int unsigned V_TOTAL = v_total(MODE);
    localparam int unsigned SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // One extra bit on the compare constants so a sync ending exactly at the total still fits.
    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] HC_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  VC_LAST   = 10'(V_TOTAL - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    if (H_TOTAL > H_TOTAL_MAX) begin : g_h_total_err
        $error("video_timing_gen: H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > V_TOTAL_MAX) begin : g_v_total_err
        $error("video_timing_gen: V_TOTAL exceeds 1024");
    end
    if (SETTLE_CYCLES < 1) begin : g_settle_err
        $error("video_timing_gen: SETTLE_CYCLES must be at least 1");
    end

    logic          lock_s;
    vtg_state_t    state;
    vtg_state_t    state_next;
    logic [SW-1:0] settle_cnt;
    logic [SW-1:0] settle_cnt_next;
    logic [10:0]   hc;
    logic [9:0]    vc;
    logic          run_ok;
    logic [11:0]   hc_ext;
    logic [10:0]   vc_ext;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WAIT_LOCK;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        settle_cnt_next = '0;
        unique case (state)
            ST_WAIT_LOCK: begin
                if (lock_s) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_next = ST_WAIT_LOCK;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    settle_cnt_next = settle_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) state_next = ST_WAIT_LOCK;
            end
            default: state_next = ST_WAIT_LOCK;
        endcase
    end

    // Gating on lock_s as well as the state lets every output go idle on the
    // same edge that takes the FSM out of RUN.
    assign run_ok = (state == ST_RUN) && lock_s;
    assign hc_ext = {1'b0, hc};
    assign vc_ext = {1'b0, vc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (!run_ok) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == HC_LAST) begin
            hc <= '0;
            vc <= (vc == VC_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= !HS_POL;
            vsync       <= !VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            running <= (state_next == ST_RUN);
            if (run_ok) begin
                hsync       <= (hc_ext >= HS_BEG && hc_ext < HS_END) ? HS_POL : !HS_POL;
                vsync       <= (vc_ext >= VS_BEG && vc_ext < VS_END) ? VS_POL : !VS_POL;
                de          <= (hc_ext < H_ACT_END) && (vc_ext < V_ACT_END);
                x           <= hc;
                y           <= vc;
                line_start  <= (hc == '0);
                frame_start <= (hc == '0) && (vc == '0);
            end else begin
                hsync       <= !HS_POL;
                vsync       <= !VS_POL;
                de          <= 1'b0;
                x           <= '0;
                y           <= '0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule
